// File: rtl/bram_march_tester.sv
// Self-test sequencer for a byte-masked 32-bit block RAM: fill, verify, masked write, verify.
// Reports pass/fail, a saturating error count and the first failing address/data.
module bram_march_tester #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] SEED       = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [31:0]           fail_data,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic [3:0]            wmask,
  output logic                  wren
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_VER0 = 3'd2,
    S_MASK = 3'd3,
    S_VER1 = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  function automatic logic [31:0] pat(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] a32;
    logic [7:0]  b;
    a32 = 32'(a);
    b   = a32[7:0];
    return SEED ^ {b, b, b, b};
  endfunction

  function automatic logic [3:0] lane(input logic [ADDR_WIDTH-1:0] a);
    return 4'b0001 << a[1:0];
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  state_e                  state_q;
  logic                    busy_q, done_q, pass_q, wren_q, first_q;
  logic [7:0]              err_q;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, raddr_q, waddr_q;
  logic [31:0]             fail_data_q, wdata_q;
  logic [3:0]              wmask_q;
  logic                    rd_en_q;
  // The compare stage carries its own address and phase so the final
  // VER0 word is still judged after the state has moved on to MASK.
  logic                    cmp_valid_q, cmp_ver1_q;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q;

  logic [31:0]             exp_s;
  logic                    mismatch_s;
  logic [7:0]              err_d;
  logic [ADDR_WIDTH-1:0]   waddr_inc_s;

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign raddr     = raddr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wmask     = wmask_q;
  assign wren      = wren_q;

  assign waddr_inc_s = waddr_q + ONE_ADDR;

  // Expected word, mismatch detection and saturating error count.
  always_comb begin
    exp_s      = pat(cmp_addr_q);
    mismatch_s = 1'b0;
    err_d      = err_q;
    if (cmp_ver1_q) begin
      exp_s = pat(cmp_addr_q) ^ lane_bits(lane(cmp_addr_q));
    end else begin
      exp_s = pat(cmp_addr_q);
    end
    mismatch_s = cmp_valid_q && (rdata != exp_s);
    if (mismatch_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Sequencer, compare pipeline and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 8'd0;
      first_q     <= 1'b0;
      fail_addr_q <= ZERO_ADDR;
      fail_data_q <= 32'd0;
      raddr_q     <= ZERO_ADDR;
      rd_en_q     <= 1'b0;
      waddr_q     <= ZERO_ADDR;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
      wren_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_ver1_q  <= 1'b0;
      cmp_addr_q  <= ZERO_ADDR;
    end else begin
      cmp_valid_q <= rd_en_q;
      cmp_addr_q  <= raddr_q;
      cmp_ver1_q  <= (state_q == S_VER1);
      err_q       <= err_d;
      if (mismatch_s && !first_q) begin
        first_q     <= 1'b1;
        fail_addr_q <= cmp_addr_q;
        fail_data_q <= rdata;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_FILL;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 8'd0;
            first_q     <= 1'b0;
            fail_addr_q <= ZERO_ADDR;
            fail_data_q <= 32'd0;
            wren_q      <= 1'b1;
            wmask_q     <= 4'hF;
            waddr_q     <= ZERO_ADDR;
            wdata_q     <= pat(ZERO_ADDR);
          end
        end
        S_FILL, S_MASK: begin
          if (waddr_q == LAST_ADDR) begin
            state_q <= (state_q == S_FILL) ? S_VER0 : S_VER1;
            wren_q  <= 1'b0;
            wmask_q <= 4'd0;
            rd_en_q <= 1'b1;
            raddr_q <= ZERO_ADDR;
          end else if (state_q == S_FILL) begin
            waddr_q <= waddr_inc_s;
            wdata_q <= pat(waddr_inc_s);
          end else begin
            waddr_q <= waddr_inc_s;
            wmask_q <= lane(waddr_inc_s);
            wdata_q <= ~pat(waddr_inc_s);
          end
        end
        S_VER0, S_VER1: begin
          if (rd_en_q) begin
            if (raddr_q == LAST_ADDR) begin
              rd_en_q <= 1'b0;
            end else begin
              raddr_q <= raddr_q + ONE_ADDR;
            end
          end else if (state_q == S_VER0) begin
            state_q <= S_MASK;
            wren_q  <= 1'b1;
            wmask_q <= lane(ZERO_ADDR);
            waddr_q <= ZERO_ADDR;
            wdata_q <= ~pat(ZERO_ADDR);
          end else begin
            // err_d already includes the last VER1 compare landing this edge.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          wren_q  <= 1'b0;
          wmask_q <= 4'd0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_march_tester.sv
// Bench for bram_march_tester: behavioural RAM with injectable faults, a cycle-indexed
// expectation model of the march sequence, and a result predictor per run.
module tb_bram_march_tester;
  localparam int AW  = 8;
  localparam int D   = 256;
  localparam int RUN = 4 * D + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, start2;
  logic          busy, done, pass, wren;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_addr, raddr, waddr;
  logic [31:0]   fail_data, rdata, wdata;
  logic [3:0]    wmask;
  logic          busy2, done2, pass2, wren2;
  logic [7:0]    err2;
  logic [AW-1:0] fail_addr2, raddr2, waddr2;
  logic [31:0]   fail_data2, rdata2, wdata2;
  logic [3:0]    wmask2;

  logic [31:0] mem  [D];
  logic [31:0] mem2 [D];
  int fault_mode;   // 0 ideal, 1 stuck-at-1 bit, 2 RAM ignores wmask
  int f_addr, f_bit;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  bit active = 1'b0;
  bit arm    = 1'b0;
  bit probe_w3 = 1'b0;
  int e_err, e_fa;
  logic [31:0] e_fd;

  bram_march_tester #(.ADDR_WIDTH(AW), .SEED(32'h0000_0000)) dut (
    .clock(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata), .wmask(wmask), .wren(wren)
  );

  bram_march_tester #(.ADDR_WIDTH(AW), .SEED(32'hA5A5_A5A5)) dut2 (
    .clock(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_addr(fail_addr2), .fail_data(fail_data2),
    .raddr(raddr2), .rdata(rdata2), .waddr(waddr2), .wdata(wdata2), .wmask(wmask2), .wren(wren2)
  );

  // Behavioural RAM for the main DUT, with fault injection.
  always @(posedge clk) begin
    if (wren)
      for (int i = 0; i < 4; i++)
        if (fault_mode == 2 || wmask[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata <= mem[raddr] | ((fault_mode == 1 && int'(raddr) == f_addr) ? (32'd1 << f_bit) : 32'd0);
  end

  // Ideal RAM for the seeded DUT.
  always @(posedge clk) begin
    if (wren2)
      for (int i = 0; i < 4; i++)
        if (wmask2[i]) mem2[waddr2][i*8 +: 8] <= wdata2[i*8 +: 8];
    rdata2 <= mem2[raddr2];
  end

  function automatic logic [31:0] pf(input logic [31:0] seed, input int a);
    return seed ^ ((32'(a) & 32'h0000_00FF) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] qf(input logic [31:0] seed, input int a);
    return pf(seed, a) ^ (32'h0000_00FF << (8 * (a % 4)));
  endfunction

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d act=%h exp=%h", name, t, act, exp);
    end
  endtask

  // Predicts the end-of-run result from the RAM's fault behaviour, word by word.
  task automatic predict();
    int n;
    logic [31:0] good, obs;
    n = 0; e_fa = 0; e_fd = 32'd0;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < D; a++) begin
        good = (ph == 0) ? pf(32'd0, a) : qf(32'd0, a);
        obs  = (ph == 0) ? pf(32'd0, a) : ((fault_mode == 2) ? ~pf(32'd0, a) : qf(32'd0, a));
        if (fault_mode == 1 && a == f_addr) obs = obs | (32'd1 << f_bit);
        if (obs != good) begin
          if (n == 0) begin e_fa = a; e_fd = obs; end
          if (n < 255) n++;
        end
      end
    e_err = n;
  endtask

  task automatic step();
    bit fill, msk, rd, chk_res;
    int wa, ra;
    logic [103:0] av, ev;
    @(negedge clk);
    if (arm) begin arm = 1'b0; active = 1'b1; t = 0; predict(); end
    if (active) begin
      fill = (t < D);
      msk  = (t >= 2*D+1) && (t < 3*D+1);
      wa   = fill ? t : t - (2*D+1);
      rd   = ((t >= D) && (t < 2*D)) || ((t >= 3*D+1) && (t < 4*D+1));
      ra   = (t < 2*D) ? t - D : t - (3*D+1);
      chk_res = (t <= D+1) || (t >= RUN);
      av = '0; ev = '0;
      av[103:96] = {busy, done, pass, wren, wmask};
      ev[103:96] = {(t < RUN), (t >= RUN), (t >= RUN) && (e_err == 0), fill || msk,
                    fill ? 4'hF : (msk ? (4'b0001 << (wa % 4)) : 4'h0)};
      if (fill || msk) begin
        av[95:56] = {8'(waddr), wdata};
        ev[95:56] = {8'(wa), fill ? pf(32'd0, wa) : ~pf(32'd0, wa)};
      end
      if (rd) begin
        av[55:48] = 8'(raddr);
        ev[55:48] = 8'(ra);
      end
      if (chk_res) begin
        av[47:0] = {err_count, 8'(fail_addr), fail_data};
        ev[47:0] = (t >= RUN) ? {8'(e_err), 8'(e_fa), e_fd} : 48'd0;
      end
      check("cyc", av, ev);
      if (probe_w3 && t == 3*D+5) check("ver1_word3", {72'd0, rdata}, {72'd0, 32'hFC03_0303});
      t++;
    end
  endtask

  task automatic pulse_start();
    if (!busy) arm = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done();
    int k;
    k = 0;
    while (!done && k < RUN + 20) begin step(); k++; end
    check("done_reached", {103'd0, done}, {103'd0, 1'b1});
    check("done_time", 104'(t), 104'(RUN + 1));
    step(); step();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 4)) step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start2 = 1'b0;
    fault_mode = 0; f_addr = 0; f_bit = 0;
    #2 reset = 1'b1;
    #1 check("reset_state", {35'd0, busy, done, pass, wren, wmask, err_count, 8'(fail_addr), fail_data, 8'(raddr), 8'(waddr)},
             104'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;

    // Model pins and ideal run.
    check("model_q3", {72'd0, qf(32'd0, 3)}, {72'd0, 32'hFC03_0303});
    check("model_seed_p1", {72'd0, pf(32'hA5A5_A5A5, 1)}, {72'd0, 32'hA4A4_A4A4});
    probe_w3 = 1'b1;
    gap(); pulse_start(); run_to_done();
    probe_w3 = 1'b0;
    check("ideal_result", {93'd0, pass, err_count, done, 1'b0}, {93'd0, 1'b1, 8'd0, 1'b1, 1'b0});

    // Stuck-at-1 on bit 5 of word 0x10.
    fault_mode = 1; f_addr = 16; f_bit = 5;
    gap(); pulse_start(); run_to_done();
    check("stuck_result", {55'd0, pass, err_count, 8'(fail_addr), fail_data},
          {55'd0, 1'b0, 8'd1, 8'h10, 32'h1010_1030});

    // RAM ignoring byte enables: every VER1 word fails.
    fault_mode = 2;
    gap(); pulse_start(); run_to_done();
    check("nomask_result", {55'd0, pass, err_count, 8'(fail_addr), fail_data},
          {55'd0, 1'b0, 8'd255, 8'h00, 32'hFFFF_FFFF});

    // Reset in the middle of FILL, then a fresh run.
    fault_mode = 0;
    gap(); pulse_start();
    while (t <= 100) step();
    reset = 1'b1;
    #1 check("midrun_reset", {35'd0, busy, done, pass, wren, wmask, err_count, 8'(fail_addr), fail_data, 8'(raddr), 8'(waddr)},
             104'd0);
    active = 1'b0;
    @(negedge clk); reset = 1'b0;
    gap(); pulse_start(); run_to_done();
    check("after_reset_pass", {103'd0, pass}, {103'd0, 1'b1});

    // start while busy is ignored; start in DONE re-runs.
    gap(); pulse_start();
    while (t < 500) step();
    pulse_start();
    repeat ($urandom_range(1, 300)) step();
    pulse_start();
    run_to_done();
    pulse_start();
    run_to_done();
    check("rerun_pass", {95'd0, pass, err_count}, {95'd0, 1'b1, 8'd0});

    // Randomised single stuck bits.
    for (int r = 0; r < 3; r++) begin
      fault_mode = 1; f_addr = $urandom_range(0, D-1); f_bit = $urandom_range(0, 31);
      gap(); pulse_start(); run_to_done();
    end
    fault_mode = 0;

    // Seeded instance: first writes and final result.
    start2 = 1'b1; step(); start2 = 1'b0;
    check("seed_w0", {63'd0, wren2, 8'(waddr2), wdata2}, {63'd0, 1'b1, 8'h00, 32'hA5A5_A5A5});
    step();
    check("seed_w1", {63'd0, wren2, 8'(waddr2), wdata2}, {63'd0, 1'b1, 8'h01, 32'hA4A4_A4A4});
    for (int k = 0; k < RUN + 20 && !done2; k++) step();
    check("seed_result", {94'd0, done2, pass2, err2}, {94'd0, 1'b1, 1'b1, 8'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
